// File: rtl/led_sequencer.sv
// LED pattern generator: a prescaler steps a WIDTH-bit pattern by rotate-left,
// rotate-right, bounce or blink, with step-tick and end-of-sweep wrap pulses.
module led_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 5000000,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [WIDTH-1:0] r_led;
  logic [CNT_W-1:0] r_count;
  dir_t             r_dir;
  logic             r_tick;
  logic             r_wrap;
  logic             w_step;
  mode_t            w_mode;

  assign w_step = en && (r_count == CNT_LAST);
  assign w_mode = mode_t'(mode);

  // Prescaler, pattern and bounce direction; load overrides any step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led   <= WIDTH'(1);
      r_count <= '0;
      r_dir   <= DIR_LEFT;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (load) begin
        r_led   <= load_val;
        r_count <= '0;
        r_dir   <= DIR_LEFT;
      end else if (en) begin
        if (w_step) begin
          r_count <= '0;
          r_tick  <= 1'b1;
          case (w_mode)
            MODE_ROL: begin
              r_led  <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
              r_wrap <= r_led[WIDTH-1];
            end
            MODE_ROR: begin
              r_led  <= {r_led[0], r_led[WIDTH-1:1]};
              r_wrap <= r_led[0];
            end
            MODE_BOUNCE: begin
              // Reversal happens on the step that finds the end bit lit.
              if (r_dir == DIR_LEFT) begin
                if (r_led[WIDTH-1]) begin
                  r_led  <= r_led >> 1;
                  r_dir  <= DIR_RIGHT;
                  r_wrap <= 1'b1;
                end else begin
                  r_led <= r_led << 1;
                end
              end else begin
                if (r_led[0]) begin
                  r_led  <= r_led << 1;
                  r_dir  <= DIR_LEFT;
                  r_wrap <= 1'b1;
                end else begin
                  r_led <= r_led >> 1;
                end
              end
            end
            MODE_BLINK: begin
              r_led <= ~r_led;
            end
            default: begin
              r_led <= r_led;
            end
          endcase
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign led  = r_led;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: DIV=4 instance for rotate/bounce/hold/load,
// DIV=1 instance for blink.
module tb_led_sequencer;

  logic       clk;
  logic       rst;
  logic       en_a, load_a, en_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] load_val_a;
  logic [7:0] led_a, led_b;
  logic       tick_a, wrap_a, tick_b, wrap_b;

  int n_checks = 0;
  int n_fails  = 0;

  led_sequencer #(.WIDTH(8), .DIV(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .load(load_a),
    .load_val(load_val_a), .led(led_a), .tick(tick_a), .wrap(wrap_a)
  );

  led_sequencer #(.WIDTH(8), .DIV(1), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .load(1'b0),
    .load_val(8'h00), .led(led_b), .tick(tick_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, check reset state, release with en=1.
  task automatic do_reset(input logic [1:0] m);
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; load_a = 1'b0; mode_a = m;
    edges(1);
    check("rst_led", 32'(led_a), 32'h01);
    check("rst_tick", 32'(tick_a), 32'h0);
    check("rst_wrap", 32'(wrap_a), 32'h0);
    rst = 1'b1; en_a = 1'b1;
  endtask

  logic [7:0] bounce_exp [16];

  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; load_a = 1'b0;
    mode_a = 2'b00; mode_b = 2'b11; load_val_a = 8'h00;
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    #2;

    // 1: rotate-left
    do_reset(2'b00);
    edges(3);
    check("rol_e3_led", 32'(led_a), 32'h01);
    check("rol_e3_tick", 32'(tick_a), 32'h0);
    edges(1);
    check("rol_e4_led", 32'(led_a), 32'h02);
    check("rol_e4_tick", 32'(tick_a), 32'h1);
    check("rol_e4_wrap", 32'(wrap_a), 32'h0);
    edges(1);
    check("rol_e5_tick", 32'(tick_a), 32'h0);
    edges(23);
    check("rol_e28_led", 32'(led_a), 32'h80);
    edges(4);
    check("rol_e32_led", 32'(led_a), 32'h01);
    check("rol_e32_tick", 32'(tick_a), 32'h1);
    check("rol_e32_wrap", 32'(wrap_a), 32'h1);

    // 2: rotate-right
    do_reset(2'b01);
    edges(4);
    check("ror_e4_led", 32'(led_a), 32'h80);
    check("ror_e4_wrap", 32'(wrap_a), 32'h1);
    edges(4);
    check("ror_e8_led", 32'(led_a), 32'h40);
    check("ror_e8_wrap", 32'(wrap_a), 32'h0);

    // 3: bounce, wrap only on steps 8 (edge 32) and 15 (edge 60)
    do_reset(2'b10);
    for (int s = 0; s < 16; s++) begin
      edges(4);
      check($sformatf("bnc_s%0d_led", s + 1), 32'(led_a), 32'(bounce_exp[s]));
      check($sformatf("bnc_s%0d_tick", s + 1), 32'(tick_a), 32'h1);
      check($sformatf("bnc_s%0d_wrap", s + 1), 32'(wrap_a),
            (s == 7 || s == 14) ? 32'h1 : 32'h0);
    end

    // 4: blink on the DIV=1 instance
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    edges(1);
    check("blk_rst_led", 32'(led_b), 32'h01);
    rst = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edges(1);
      check($sformatf("blk_e%0d_led", i + 1), 32'(led_b), (i % 2 == 0) ? 32'hFE : 32'h01);
      check($sformatf("blk_e%0d_tick", i + 1), 32'(tick_b), 32'h1);
      check($sformatf("blk_e%0d_wrap", i + 1), 32'(wrap_b), 32'h0);
    end
    en_b = 1'b0;

    // 5: en=0 hold at count=2
    do_reset(2'b00);
    edges(2);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("hold_led", 32'(led_a), 32'h01);
      check("hold_tick", 32'(tick_a), 32'h0);
    end
    en_a = 1'b1;
    edges(1);
    check("resume_e1_led", 32'(led_a), 32'h01);
    check("resume_e1_tick", 32'(tick_a), 32'h0);
    edges(1);
    check("resume_e2_led", 32'(led_a), 32'h02);
    check("resume_e2_tick", 32'(tick_a), 32'h1);

    // 6: load mid-count, then async reset mid-cycle
    do_reset(2'b00);
    edges(6);
    check("ld_pre_led", 32'(led_a), 32'h02);
    load_a = 1'b1; load_val_a = 8'hA5;
    edges(1);
    load_a = 1'b0;
    check("ld_led", 32'(led_a), 32'hA5);
    check("ld_tick", 32'(tick_a), 32'h0);
    edges(3);
    check("ld_e3_led", 32'(led_a), 32'hA5);
    check("ld_e3_tick", 32'(tick_a), 32'h0);
    edges(1);
    check("ld_e4_led", 32'(led_a), 32'h4B);
    check("ld_e4_tick", 32'(tick_a), 32'h1);
    check("ld_e4_wrap", 32'(wrap_a), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_led", 32'(led_a), 32'h01);
    check("async_rst_tick", 32'(tick_a), 32'h0);
    edges(1);
    rst = 1'b1;

    // load with en=0 still loads, including an all-zero value
    en_a = 1'b0; load_a = 1'b1; load_val_a = 8'h00;
    edges(1);
    load_a = 1'b0;
    check("ld_en0_led", 32'(led_a), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
